mdio_transmisor: RTL and testbench
==================================

MDIO_TRANSMISOR -- requirements
Module: mdio_transmisor

Interface
REQ-001 Parameter: MDC_HALF, 1, clk cycles per MDC half-period; legal values >= 1.
REQ-002 Port: clk  input  1  system clock; all logic on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: mdio_start  input  1  one-cycle request to send a frame; ignored while busy=1.
REQ-005 Port: t_data  input  32  frame word {ST[31:30], OP[29:28], PHYAD[27:23], REGAD[22:18], TA[17:16], DATA[15:0]}.
REQ-006 Port: mdio_in  input  1  serial data from PHY, used during read turnaround and data.
REQ-007 Port: mdc  output  1  management clock to PHY.
REQ-008 Port: mdio_out  output  1  serial data to PHY.
REQ-009 Port: mdio_oe  output  1  1 = controller drives MDIO line.
REQ-010 Port: rd_data  output  16  data captured in last read frame.
REQ-011 Port: data_rdy  output  1  one-clk pulse at frame end.
REQ-012 Port: busy  output  1  high from start acceptance to frame end.

Function
REQ-013 States SHALL be IDLE, PREAMBLE, HEADER, WR_DATA, RD_TA, RD_DATA, DONE.
REQ-014 On mdio_start=1 in IDLE: t_data latched, busy=1 at that edge (E0), next state PREAMBLE, or HEADER if preamble compiled out.
REQ-015 mdc SHALL be low in IDLE; while busy it toggles every MDC_HALF clks, starting low at E0; bit period = 2*MDC_HALF clks.
REQ-016 mdio_out SHALL change only at edges where mdc goes 1->0 (or E0); each bit held for one full mdc period, stable across mdc rise.
REQ-017 PREAMBLE: 32 bits of 1, mdio_oe=1.
REQ-018 HEADER: 14 bits t_data[31:18], MSB first, mdio_oe=1.
REQ-019 OP==2'b10 SHALL be a read; any other OP value SHALL be sent as a write.
REQ-020 WR_DATA: 18 bits t_data[17:0] MSB first, mdio_oe=1.
REQ-021 RD_TA: 2 bit periods with mdio_oe=0 and mdio_out=0; mdio_in ignored.
REQ-022 RD_DATA: mdio_oe=0; mdio_in sampled at the clk edge where mdc goes 1->0, 16 bits shifted MSB first into rd_data.
REQ-023 rd_data SHALL update only at frame end of a read; it holds its value through write frames.
REQ-024 Frame length N = 64 bits (32 without preamble); at E0 + 2*MDC_HALF*N: busy=0, mdc=0, mdio_oe=0, data_rdy=1 for exactly one clk, state IDLE via DONE.
REQ-025 mdio_start asserted in the same cycle busy falls SHALL be ignored; a new frame is accepted no earlier than the next cycle.
REQ-026 Bit counter SHALL count down without wrap; no bits are emitted beyond N.

Reset
REQ-027 reset=0 SHALL immediately force IDLE: mdc=0, mdio_out=0, mdio_oe=0, rd_data=0, data_rdy=0, busy=0, counters and latched frame cleared.
REQ-028 Reset mid-frame SHALL abort with no data_rdy pulse; no mdc edge is produced after reset asserts.

Configuration
REQ-029 Macro MDIO_PREAMBLE_EN defined: 32-bit preamble sent before each frame (N=64).
REQ-030 MDIO_PREAMBLE_EN undefined: PREAMBLE state absent, frame starts at ST (N=32); all other behaviour unchanged.

Verification
REQ-031 Write: t_data=32'h508A4546, MDC_HALF=1, preamble on -> 32 ones then 0101_00001_00010_10_0100010101000110 on mdio_out, mdio_oe=1 throughout, data_rdy at E0+128.
REQ-032 Read: t_data=32'h60880000, PHY returns 16'hBEEF after TA -> mdio_oe=0 for last 18 bits, rd_data=16'hBEEF at data_rdy.
REQ-033 mdio_start pulsed at E0+40 during busy frame -> ignored, exactly one data_rdy pulse, no second frame.
REQ-034 reset=0 at E0+70 of a read -> all outputs zero immediately, no data_rdy, rd_data=0; a subsequent write completes normally.
REQ-035 MDIO_PREAMBLE_EN undefined, MDC_HALF=3, write 32'h508A4546 -> first bit 0 at E0, mdc period 6 clks, data_rdy at E0+192.

Source files
------------

// File: rtl/mdio_transmisor_if.sv
// mdio_transmisor_if
// Groups the request, PHY-data and status signals of the MDIO frame
// transmitter so host logic and the transmitter connect through one bundle.
//
// Signals:
//   mdio_start  host -> xmtr  one-cycle frame request
//   t_data      host -> xmtr  32-bit frame word {ST,OP,PHYAD,REGAD,TA,DATA}
//   mdio_in     PHY  -> xmtr  serial read data from the PHY
//   mdc         xmtr -> PHY   management clock
//   mdio_out    xmtr -> PHY   serial data towards the PHY
//   mdio_oe     xmtr -> pad   1 = transmitter drives the MDIO line
//   rd_data     xmtr -> host  data captured by the last read frame
//   data_rdy    xmtr -> host  one-clk pulse at frame end
//   busy        xmtr -> host  frame in progress
//
// Modports:
//   master  the requesting side (host logic / PHY model)
//   slave   the frame transmitter itself
interface mdio_transmisor_if;
  logic        mdio_start;
  logic [31:0] t_data;
  logic        mdio_in;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic [15:0] rd_data;
  logic        data_rdy;
  logic        busy;

  modport master (
    output mdio_start, t_data, mdio_in,
    input  mdc, mdio_out, mdio_oe, rd_data, data_rdy, busy
  );

  modport slave (
    input  mdio_start, t_data, mdio_in,
    output mdc, mdio_out, mdio_oe, rd_data, data_rdy, busy
  );
endinterface

// File: rtl/mdio_transmisor.sv
// mdio_transmisor
// Serialises one 32-bit MDIO management frame onto mdc/mdio_out, optionally
// preceded by a 32-bit all-ones preamble. OP==2'b10 frames are reads: the
// line is released after the 14 header bits and 16 data bits are shifted in
// from the PHY. Everything else is sent as a write of t_data[17:0].
//
// Parameters:
//   MDC_HALF  clk cycles per mdc half-period (>= 1)
//
// Ports:
//   clk    system clock, all logic on posedge
//   reset  asynchronous, active-low reset
//   bus    mdio_transmisor_if.slave (start/t_data/mdio_in in,
//          mdc/mdio_out/mdio_oe/rd_data/data_rdy/busy out)
//
// Configuration macro:
//   MDIO_PREAMBLE_EN  defined: 64-bit frames with 32-bit preamble
//                     undefined: 32-bit frames starting directly at ST
module mdio_transmisor #(
  parameter int MDC_HALF = 1
) (
  input  logic              clk,
  input  logic              reset,
  mdio_transmisor_if.slave  bus
);

  localparam int DIV_W = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MDC_HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
`ifdef MDIO_PREAMBLE_EN
    PREAMBLE,
`endif
    HEADER,
    WR_DATA,
    RD_TA,
    RD_DATA,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             mdc_q, mdc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0]      frame_q, frame_d;
  logic [15:0]      shift_q, shift_d;
  logic [15:0]      rdData_q, rdData_d;
  logic             rdFlag_q, rdFlag_d;
  logic             out_q, out_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;
  logic             bitEdge;

  // A bit period ends on the clk edge where mdc is about to fall; every
  // state transition and every mdio_in sample happens on exactly that edge.
  assign bitEdge = busy_q & mdc_q & (div_q == DIV_LAST);

  assign bus.mdc      = mdc_q;
  assign bus.mdio_out = out_q;
  assign bus.mdio_oe  = oe_q;
  assign bus.rd_data  = rdData_q;
  assign bus.data_rdy = rdy_q;
  assign bus.busy     = busy_q;

  // Next-state logic. frame_q[31] always holds the next header/data bit to
  // emit, so loading a bit is "drive frame_q[31], shift left". cnt_q holds
  // the number of bits still to follow the current one inside the state.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    mdc_d    = mdc_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    shift_d  = shift_q;
    rdData_d = rdData_q;
    rdFlag_d = rdFlag_q;
    out_d    = out_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    rdy_d    = 1'b0;

    if (busy_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        mdc_d = ~mdc_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.mdio_start) begin
          busy_d   = 1'b1;
          mdc_d    = 1'b0;
          div_d    = '0;
          oe_d     = 1'b1;
          shift_d  = '0;
          rdFlag_d = (bus.t_data[29:28] == 2'b10);
`ifdef MDIO_PREAMBLE_EN
          state_d  = PREAMBLE;
          cnt_d    = 5'd31;
          out_d    = 1'b1;
          frame_d  = bus.t_data;
`else
          state_d  = HEADER;
          cnt_d    = 5'd13;
          out_d    = bus.t_data[31];
          frame_d  = {bus.t_data[30:0], 1'b0};
`endif
        end
      end

`ifdef MDIO_PREAMBLE_EN
      PREAMBLE: begin
        if (bitEdge) begin
          if (cnt_q == 5'd0) begin
            state_d = HEADER;
            cnt_d   = 5'd13;
            out_d   = frame_q[31];
            frame_d = {frame_q[30:0], 1'b0};
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
`endif

      HEADER: begin
        if (bitEdge) begin
          if (cnt_q == 5'd0) begin
            if (rdFlag_q) begin
              state_d = RD_TA;
              cnt_d   = 5'd1;
              out_d   = 1'b0;
              oe_d    = 1'b0;
            end else begin
              state_d = WR_DATA;
              cnt_d   = 5'd17;
              out_d   = frame_q[31];
              frame_d = {frame_q[30:0], 1'b0};
            end
          end else begin
            cnt_d   = cnt_q - 5'd1;
            out_d   = frame_q[31];
            frame_d = {frame_q[30:0], 1'b0};
          end
        end
      end

      WR_DATA: begin
        if (bitEdge) begin
          if (cnt_q == 5'd0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            mdc_d   = 1'b0;
            div_d   = '0;
            out_d   = 1'b0;
            oe_d    = 1'b0;
            rdy_d   = 1'b1;
          end else begin
            cnt_d   = cnt_q - 5'd1;
            out_d   = frame_q[31];
            frame_d = {frame_q[30:0], 1'b0};
          end
        end
      end

      RD_TA: begin
        if (bitEdge) begin
          if (cnt_q == 5'd0) begin
            state_d = RD_DATA;
            cnt_d   = 5'd15;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end

      // The final sample lands on the frame-end edge itself, so rd_data is
      // loaded from the shift register plus the bit being sampled right now.
      RD_DATA: begin
        if (bitEdge) begin
          shift_d = {shift_q[14:0], bus.mdio_in};
          if (cnt_q == 5'd0) begin
            state_d  = DONE;
            busy_d   = 1'b0;
            mdc_d    = 1'b0;
            div_d    = '0;
            out_d    = 1'b0;
            oe_d     = 1'b0;
            rdy_d    = 1'b1;
            rdData_d = {shift_q[14:0], bus.mdio_in};
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset forces every output low at once so no
  // further mdc edge can reach the PHY after an abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      mdc_q    <= 1'b0;
      cnt_q    <= '0;
      frame_q  <= '0;
      shift_q  <= '0;
      rdData_q <= '0;
      rdFlag_q <= 1'b0;
      out_q    <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      mdc_q    <= mdc_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      shift_q  <= shift_d;
      rdData_q <= rdData_d;
      rdFlag_q <= rdFlag_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
    end
  end

endmodule

// File: tb/tb_mdio_transmisor.sv
// tb_mdio_transmisor
// Directed bench for mdio_transmisor. With MDIO_PREAMBLE_EN defined it runs
// 64-bit frames at MDC_HALF=1; otherwise 32-bit frames at MDC_HALF=3.
module tb_mdio_transmisor;

`ifdef MDIO_PREAMBLE_EN
  localparam int H   = 1;
  localparam int PRE = 32;
`else
  localparam int H   = 3;
  localparam int PRE = 0;
`endif
  localparam int N         = PRE + 32;
  localparam int FRAME_CYC = 2 * H * N;

  logic        clk;
  logic        reset;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] lastRd;

  mdio_transmisor_if bus();

  mdio_transmisor #(.MDC_HALF(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to just after the next rising edge so outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Packs the serial-side status into {busy, mdc, oe, out, data_rdy}.
  function automatic logic [4:0] outVec();
    return {bus.busy, bus.mdc, bus.mdio_oe, bus.mdio_out, bus.data_rdy};
  endfunction

  // Runs one frame and checks every cycle against the expected waveform.
  // abortAt >= 0 asserts reset at that cycle offset from E0; extraStartAt
  // pulses mdio_start during the frame; lateStart pulses it as busy falls.
  task automatic applyStimulus(input logic [31:0] word, input logic [15:0] phyWord,
                               input int abortAt, input int extraStartAt,
                               input bit lateStart);
    logic       isRead;
    logic       bitExp;
    logic       mdcExp;
    logic [4:0] expVec;
    int         k;
    isRead = (word[29:28] == 2'b10);
    k = 0;
    bus.t_data = word;
    bus.mdio_start = 1'b1;
    tick();
    bus.mdio_start = 1'b0;
    for (int c = 0; c <= FRAME_CYC; c++) begin
      if (c > 0) tick();
      if (c == abortAt) begin
        reset = 1'b0;
        #1;
        checkOutput("abort outputs", {27'd0, outVec()}, 32'd0);
        checkOutput("abort rd_data", {16'd0, bus.rd_data}, 32'd0);
        for (int r = 0; r < 4; r++) begin
          tick();
          checkOutput("abort held", {27'd0, outVec()}, 32'd0);
        end
        reset = 1'b1;
        tick();
        checkOutput("abort release", {27'd0, outVec()}, 32'd0);
        lastRd = 16'h0000;
        return;
      end
      if (c < FRAME_CYC) begin
        k      = c / (2 * H);
        mdcExp = 1'((c / H) % 2);
        bitExp = (k < PRE) ? 1'b1 : word[31 - (k - PRE)];
        if (isRead && k >= PRE + 14) expVec = {1'b1, mdcExp, 1'b0, 1'b0, 1'b0};
        else                         expVec = {1'b1, mdcExp, 1'b1, bitExp, 1'b0};
      end else begin
        expVec = 5'b00001;
      end
      checkOutput($sformatf("frame %h c=%0d", word, c), {27'd0, outVec()},
                  {27'd0, expVec});
      if (c == FRAME_CYC) begin
        if (isRead) lastRd = phyWord;
        checkOutput("rd_data at data_rdy", {16'd0, bus.rd_data}, {16'd0, lastRd});
      end
      if (isRead && c < FRAME_CYC && k >= PRE + 16)
        bus.mdio_in = phyWord[15 - (k - PRE - 16)];
      else
        bus.mdio_in = 1'($urandom_range(0, 1));
      bus.mdio_start = (c == extraStartAt) || (lateStart && c == FRAME_CYC);
    end
    tick();
    bus.mdio_start = 1'b0;
    checkOutput("after frame", {27'd0, outVec()}, 32'd0);
    for (int r = 0; r < 3; r++) begin
      tick();
      checkOutput("idle", {27'd0, outVec()}, 32'd0);
    end
    checkOutput("rd_data hold", {16'd0, bus.rd_data}, {16'd0, lastRd});
  endtask

  // Directed sequence: reset, write, read, ignored starts, abort, recovery.
  initial begin
    reset = 1'b0;
    bus.mdio_start = 1'b0;
    bus.t_data = '0;
    bus.mdio_in = 1'b0;
    lastRd = 16'h0000;
    #12;
    checkOutput("reset outputs", {27'd0, outVec()}, 32'd0);
    checkOutput("reset rd_data", {16'd0, bus.rd_data}, 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("post reset idle", {27'd0, outVec()}, 32'd0);

    applyStimulus(32'h508A4546, 16'h0000, -1, -1, 1'b0);
    applyStimulus(32'h60880000, 16'hBEEF, -1, -1, 1'b0);
    applyStimulus(32'h508A4546, 16'h0000, -1, 40, 1'b1);
    applyStimulus(32'h60880000, 16'h1234, 70, -1, 1'b0);
    applyStimulus(32'h508A4546, 16'h0000, -1, -1, 1'b0);
    applyStimulus(32'h7ABCC3A5, 16'h0000, -1, -1, 1'b0);
    applyStimulus(32'h41230F0F, 16'h0000, -1, -1, 1'b0);
    applyStimulus(32'h6ACE0000, 16'hA5C3, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
